pipe_mem_arbiter: RTL and testbench
===================================

Name: pipe_mem_arbiter

Overview:
- Shares one synchronous single-port RAM between three requesters: the IF stage (instruction fetch), the MEM stage (load/store) and a loader/debug port (LD).
- Sequences every access as issue, wait for RAM latency, then acknowledge.
- Raises a pipeline stall while IF or MEM is waiting, so PC and the pipeline registers hold.
- Sits between the pipeline stages and the RAM, in place of separate instruction ROM and data RAM ports.

Parameters:
- RAM_LAT, 1, RAM read latency in clock cycles from the ram_en cycle to valid ram_rdata; legal range 1..7.
- STARVE_LIMIT, 4, number of consecutive arbitration losses of IF to MEM before IF is forced ahead of MEM; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  IF fetch request; held until if_ack
- if_addr  in  32  IF word address
- if_rdata  out  32  fetched instruction; valid while if_ack=1
- if_ack  out  1  one-cycle completion pulse for IF
- mem_req  in  1  MEM-stage request; held until mem_ack
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  MEM-stage address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data; valid while mem_ack=1
- mem_ack  out  1  one-cycle completion pulse for MEM
- ld_req  in  1  loader request; held until ld_ack
- ld_we  in  1  loader write enable
- ld_addr  in  32  loader address
- ld_wdata  in  32  loader write data
- ld_rdata  out  32  loader read data; valid while ld_ack=1
- ld_ack  out  1  one-cycle completion pulse for LD
- ram_en  out  1  RAM access strobe, exactly one cycle per access
- ram_we  out  1  RAM write enable, qualified by ram_en
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data
- grant_id  out  2  current owner: 0 none, 1 IF, 2 MEM, 3 LD
- stall  out  1  (if_req & ~if_ack) | (mem_req & ~mem_ack), combinational

Behaviour:
- Reset values:
  - FSM in IDLE; all acks, ram_en, ram_we = 0.
  - grant_id = 0; ram_addr, ram_wdata and all rdata outputs = 0.
  - Round-robin pointer favours IF; starve_cnt = 0.
- FSM states IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration: a winner is chosen from the requests sampled this cycle, in this order:
  - IF, if starve_cnt == STARVE_LIMIT and if_req=1;
  - else MEM, if mem_req=1;
  - else round-robin between IF and LD.
  - Round-robin: if both request, the one not granted last between those two wins; the pointer updates only on an IF or LD grant.
  - With a winner: its address, data and we are registered, grant_id is set, and the next state is ISSUE.
  - With no request: stay in IDLE, grant_id=0.
- ISSUE: ram_en=1 and ram_we=latched we for exactly this cycle; the latency counter loads RAM_LAT-1.
  - Next state is WAIT if RAM_LAT>1, else RESP.
- WAIT: the counter decrements each cycle; at 0 the next state is RESP.
- RESP: ram_rdata is captured into the owner's rdata register, and the owner's ack pulses for this single cycle.
  - Writes also ack here; the rdata contents are then don't-care but stable.
  - Next state is IDLE, grant_id=0.
- Latency: request sampled in IDLE at cycle T, ram_en at T+1, ack at T+1+RAM_LAT, next arbitration at T+2+RAM_LAT.
- Request rules:
  - The requester drops req on the edge after ack.
  - A req still high in the IDLE cycle after ack is a new request.
  - Address and data changes after a grant are ignored.
- rdata registers hold their value until overwritten by the next read for the same requester.
- starve_cnt, 4-bit saturating:
  - +1 each IDLE arbitration where if_req=1 and MEM wins;
  - cleared when IF is granted or when if_req=0 in IDLE.
- Simultaneous IF, MEM and LD requests: MEM wins, then IF, then LD (pointer favours IF after reset), unless starvation forces IF first.
- Reset asserted during ISSUE/WAIT/RESP:
  - The next edge returns to IDLE with all outputs at reset values.
  - A pending ack is suppressed.
  - A write already strobed in ISSUE is considered committed.
- grant_id is held constant from ISSUE through RESP.

Test Plan:
- Reset, then single IF read at if_addr=0x10 with RAM returning 0x8C010004, RAM_LAT=1 -> ram_en at T+1, if_ack and if_rdata=0x8C010004 at T+2; stall=1 during T..T+1, 0 at T+2.
- MEM store mem_addr=0x40, mem_wdata=0xDEADBEEF concurrent with if_req -> MEM granted first (grant_id=2, ram_we=1 for one cycle); IF granted in the following IDLE.
- MEM requesting back-to-back while IF requests continuously, STARVE_LIMIT=4 -> MEM wins 4 arbitrations, IF wins the 5th, starve_cnt returns to 0.
- IF and LD both requesting continuously, no MEM -> grants alternate IF, LD, IF, LD; each access spans 2+RAM_LAT cycles.
- RAM_LAT=3, LD read -> ram_en at T+1, ld_ack at T+4, ld_rdata equals ram_rdata sampled at T+4; no other ack asserted.
- Reset pulsed during WAIT of an IF read -> no if_ack; next cycle grant_id=0, ram_en=0, FSM in IDLE; a fresh if_req completes normally.

Source files
------------

// File: rtl/pipe_mem_arbiter.sv
// rtl/pipe_mem_arbiter.sv - arbiter sharing one single-port RAM between IF, MEM and loader ports
//
// Purpose: serialises instruction fetch (IF), load/store (MEM) and loader (LD)
// accesses onto one synchronous RAM. Each access runs IDLE -> ISSUE -> WAIT* ->
// RESP, and stall holds the pipeline while IF or MEM is outstanding.
//
// Ports:
//   clock_i, reset_i            clock, synchronous active-high reset
//   if_req_i/if_addr_i          IF fetch request; if_rdata_o/if_ack_o completion
//   mem_req_i/mem_we_i/...      MEM load/store request; mem_rdata_o/mem_ack_o
//   ld_req_i/ld_we_i/...        loader request; ld_rdata_o/ld_ack_o
//   ram_en_o/ram_we_o/...       RAM strobe, write enable, address, write data
//   ram_rdata_i                 RAM read data, valid RAM_LAT cycles after ram_en_o
//   grant_id_o                  current owner: 0 none, 1 IF, 2 MEM, 3 LD
//   stall_o                     IF or MEM waiting for its ack
module pipe_mem_arbiter #(
  parameter int unsigned RAM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  input  logic        ld_req_i,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_wdata_i,
  output logic [31:0] ld_rdata_o,
  output logic        ld_ack_o,
  output logic        ram_en_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i,
  output logic [1:0]  grant_id_o,
  output logic        stall_o
);

  localparam logic [1:0] ID_NONE = 2'd0;
  localparam logic [1:0] ID_IF   = 2'd1;
  localparam logic [1:0] ID_MEM  = 2'd2;
  localparam logic [1:0] ID_LD   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [1:0]  grant_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ram_en_q;
  logic        ram_we_q;
  logic [2:0]  lat_cnt_q;
  logic [3:0]  starve_q;
  logic        rr_ld_q;      // 1: LD wins the next IF/LD tie
  logic        if_ack_q;
  logic        mem_ack_q;
  logic        ld_ack_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic [31:0] ld_rdata_q;

  logic [1:0]  win_d;
  logic        win_we_d;
  logic [31:0] win_addr_d;
  logic [31:0] win_wdata_d;
  logic        resp_next_d;

  always_comb begin
    win_d       = ID_NONE;
    win_we_d    = 1'b0;
    win_addr_d  = 32'h0;
    win_wdata_d = 32'h0;
    if (if_req_i && starve_q == 4'(STARVE_LIMIT)) begin
      win_d = ID_IF;
    end else if (mem_req_i) begin
      win_d = ID_MEM;
    end else if (if_req_i && (!ld_req_i || !rr_ld_q)) begin
      win_d = ID_IF;
    end else if (ld_req_i) begin
      win_d = ID_LD;
    end
    case (win_d)
      ID_IF:  win_addr_d = if_addr_i;
      ID_MEM: begin
        win_addr_d  = mem_addr_i;
        win_wdata_d = mem_wdata_i;
        win_we_d    = mem_we_i;
      end
      ID_LD:  begin
        win_addr_d  = ld_addr_i;
        win_wdata_d = ld_wdata_i;
        win_we_d    = ld_we_i;
      end
      default: ;
    endcase
  end

  // RESP is entered straight from ISSUE when RAM_LAT is 1, otherwise once the
  // WAIT countdown is about to reach zero.
  assign resp_next_d = (state_q == S_ISSUE && RAM_LAT == 1) ||
                       (state_q == S_WAIT && lat_cnt_q == 3'd1);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      grant_q     <= ID_NONE;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      lat_cnt_q   <= 3'd0;
      starve_q    <= 4'd0;
      rr_ld_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
      ld_rdata_q  <= 32'h0;
    end else begin
      ram_en_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      if_ack_q  <= resp_next_d && grant_q == ID_IF;
      mem_ack_q <= resp_next_d && grant_q == ID_MEM;
      ld_ack_q  <= resp_next_d && grant_q == ID_LD;
      case (state_q)
        S_IDLE: begin
          if (win_d != ID_NONE) begin
            grant_q  <= win_d;
            addr_q   <= win_addr_d;
            wdata_q  <= win_wdata_d;
            we_q     <= win_we_d;
            ram_en_q <= 1'b1;
            ram_we_q <= win_we_d;
            state_q  <= S_ISSUE;
          end
          if (!if_req_i || win_d == ID_IF) begin
            starve_q <= 4'd0;
          end else if (win_d == ID_MEM && starve_q != 4'hF) begin
            starve_q <= starve_q + 4'd1;
          end
          if (win_d == ID_IF) rr_ld_q <= 1'b1;
          if (win_d == ID_LD) rr_ld_q <= 1'b0;
        end
        S_ISSUE: begin
          lat_cnt_q <= 3'(RAM_LAT - 1);
          state_q   <= resp_next_d ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          lat_cnt_q <= lat_cnt_q - 3'd1;
          if (resp_next_d) state_q <= S_RESP;
        end
        S_RESP: begin
          if (!we_q) begin
            case (grant_q)
              ID_IF:   if_rdata_q  <= ram_rdata_i;
              ID_MEM:  mem_rdata_q <= ram_rdata_i;
              ID_LD:   ld_rdata_q  <= ram_rdata_i;
              default: ;
            endcase
          end
          grant_q <= ID_NONE;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read data is forwarded from the RAM during the ack cycle and held in the
  // owner's register afterwards.
  assign if_rdata_o  = (if_ack_q && !we_q) ? ram_rdata_i : if_rdata_q;
  assign mem_rdata_o = (mem_ack_q && !we_q) ? ram_rdata_i : mem_rdata_q;
  assign ld_rdata_o  = (ld_ack_q && !we_q) ? ram_rdata_i : ld_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign mem_ack_o   = mem_ack_q;
  assign ld_ack_o    = ld_ack_q;
  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign grant_id_o  = grant_q;
  assign stall_o     = (if_req_i & ~if_ack_q) | (mem_req_i & ~mem_ack_q);

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb/tb_pipe_mem_arbiter.sv - directed self-checking bench for pipe_mem_arbiter
module tb_pipe_mem_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic clk = 1'b0;
  logic rst;
  logic if_req, mem_req, mem_we, ld_req, ld_we;
  logic [31:0] if_addr, mem_addr, mem_wdata, ld_addr, ld_wdata;

  logic [31:0] a_if_rdata, a_mem_rdata, a_ld_rdata, a_ram_addr, a_ram_wdata, a_ram_rdata;
  logic a_if_ack, a_mem_ack, a_ld_ack, a_ram_en, a_ram_we, a_stall;
  logic [1:0] a_grant;
  logic [31:0] b_if_rdata, b_mem_rdata, b_ld_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic b_if_ack, b_mem_ack, b_ld_ack, b_ram_en, b_ram_we, b_stall;
  logic [1:0] b_grant;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_mem_arbiter #(.RAM_LAT(LAT_A), .STARVE_LIMIT(4)) dut_a (
    .clock_i(clk), .reset_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(a_if_rdata), .if_ack_o(a_if_ack),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(a_mem_rdata), .mem_ack_o(a_mem_ack),
    .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
    .ld_rdata_o(a_ld_rdata), .ld_ack_o(a_ld_ack),
    .ram_en_o(a_ram_en), .ram_we_o(a_ram_we), .ram_addr_o(a_ram_addr),
    .ram_wdata_o(a_ram_wdata), .ram_rdata_i(a_ram_rdata),
    .grant_id_o(a_grant), .stall_o(a_stall)
  );

  pipe_mem_arbiter #(.RAM_LAT(LAT_B), .STARVE_LIMIT(4)) dut_b (
    .clock_i(clk), .reset_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(b_if_rdata), .if_ack_o(b_if_ack),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(b_mem_rdata), .mem_ack_o(b_mem_ack),
    .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
    .ld_rdata_o(b_ld_rdata), .ld_ack_o(b_ld_ack),
    .ram_en_o(b_ram_en), .ram_we_o(b_ram_we), .ram_addr_o(b_ram_addr),
    .ram_wdata_o(b_ram_wdata), .ram_rdata_i(b_ram_rdata),
    .grant_id_o(b_grant), .stall_o(b_stall)
  );

  // Initial RAM image: 0x10 holds an instruction word, other words carry their address.
  function automatic logic [31:0] init_word(input logic [31:0] ad);
    return (ad == 32'h10) ? 32'h8C010004 : {16'hC0DE, ad[15:0]};
  endfunction

  bit [31:0] a_wd [256];
  bit        a_wv [256];
  bit [31:0] a_pipe [8];
  bit [31:0] b_wd [256];
  bit        b_wv [256];
  bit [31:0] b_pipe [8];

  always @(posedge clk) begin
    if (a_ram_en && a_ram_we) begin
      a_wd[a_ram_addr[7:0]] <= a_ram_wdata;
      a_wv[a_ram_addr[7:0]] <= 1'b1;
    end
    a_pipe[0] <= (a_ram_en && !a_ram_we) ?
                 (a_wv[a_ram_addr[7:0]] ? a_wd[a_ram_addr[7:0]] : init_word(a_ram_addr)) : 32'h0;
    for (int i = 1; i < 8; i++) a_pipe[i] <= a_pipe[i-1];
  end

  always @(posedge clk) begin
    if (b_ram_en && b_ram_we) begin
      b_wd[b_ram_addr[7:0]] <= b_ram_wdata;
      b_wv[b_ram_addr[7:0]] <= 1'b1;
    end
    b_pipe[0] <= (b_ram_en && !b_ram_we) ?
                 (b_wv[b_ram_addr[7:0]] ? b_wd[b_ram_addr[7:0]] : init_word(b_ram_addr)) : 32'h0;
    for (int i = 1; i < 8; i++) b_pipe[i] <= b_pipe[i-1];
  end

  assign a_ram_rdata = a_pipe[LAT_A-1];
  assign b_ram_rdata = b_pipe[LAT_B-1];

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit sig_of(input int which);
    case (which)
      0: return a_ram_en;
      1: return a_if_ack;
      2: return a_mem_ack;
      3: return a_ld_ack;
      4: return b_ram_en;
      5: return b_if_ack;
      default: return b_ld_ack;
    endcase
  endfunction

  // Steps negedges until the selected output is high or the budget runs out.
  task automatic wait_sig(input int which, input int budget, output bit seen, output int n);
    n = 0;
    while (!sig_of(which) && n < budget) begin
      tick();
      n++;
    end
    seen = sig_of(which);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; ld_addr = 32'h0; ld_wdata = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++; if ({a_if_ack, a_mem_ack, a_ld_ack, a_ram_en, a_ram_we, a_stall} !== 6'b0)
      $display("FAIL reset_a_ctrl: got %b want 000000", {a_if_ack, a_mem_ack, a_ld_ack, a_ram_en, a_ram_we, a_stall}); else n_pass++;
    n_total++; if ({b_if_ack, b_mem_ack, b_ld_ack, b_ram_en, b_ram_we, b_stall} !== 6'b0)
      $display("FAIL reset_b_ctrl: got %b want 000000", {b_if_ack, b_mem_ack, b_ld_ack, b_ram_en, b_ram_we, b_stall}); else n_pass++;
    n_total++; if ({a_grant, b_grant} !== 4'd0) $display("FAIL reset_grant: got %h want 0", {a_grant, b_grant}); else n_pass++;
    n_total++; if ({a_ram_addr, a_ram_wdata, b_ram_addr, b_ram_wdata} !== 128'h0)
      $display("FAIL reset_ram_bus: got %h want 0", {a_ram_addr, a_ram_wdata, b_ram_addr, b_ram_wdata}); else n_pass++;
    n_total++; if ({a_if_rdata, a_mem_rdata, a_ld_rdata} !== 96'h0)
      $display("FAIL reset_a_rdata: got %h want 0", {a_if_rdata, a_mem_rdata, a_ld_rdata}); else n_pass++;
    n_total++; if ({b_if_rdata, b_mem_rdata, b_ld_rdata} !== 96'h0)
      $display("FAIL reset_b_rdata: got %h want 0", {b_if_rdata, b_mem_rdata, b_ld_rdata}); else n_pass++;
  endtask

  task automatic test_if_read();
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    n_total++; if (a_stall !== 1'b1) $display("FAIL if_stall_T: got %b want 1", a_stall); else n_pass++;
    tick();
    n_total++; if (a_ram_en !== 1'b1 || a_ram_we !== 1'b0) $display("FAIL if_issue: en/we %b%b want 10", a_ram_en, a_ram_we); else n_pass++;
    n_total++; if (a_ram_addr !== 32'h10) $display("FAIL if_addr: got %h want 00000010", a_ram_addr); else n_pass++;
    n_total++; if (a_grant !== 2'd1) $display("FAIL if_grant: got %0d want 1", a_grant); else n_pass++;
    n_total++; if (a_stall !== 1'b1 || a_if_ack !== 1'b0) $display("FAIL if_stall_T1: stall/ack %b%b want 10", a_stall, a_if_ack); else n_pass++;
    tick();
    n_total++; if (a_if_ack !== 1'b1 || a_ram_en !== 1'b0) $display("FAIL if_ack_T2: ack/en %b%b want 10", a_if_ack, a_ram_en); else n_pass++;
    n_total++; if (a_if_rdata !== 32'h8C010004) $display("FAIL if_rdata: got %h want 8c010004", a_if_rdata); else n_pass++;
    n_total++; if (a_stall !== 1'b0) $display("FAIL if_stall_T2: got %b want 0", a_stall); else n_pass++;
    if_req = 1'b0;
    tick();
    n_total++; if (a_if_ack !== 1'b0 || a_grant !== 2'd0) $display("FAIL if_after: ack/grant %b/%0d want 0/0", a_if_ack, a_grant); else n_pass++;
    n_total++; if (a_if_rdata !== 32'h8C010004) $display("FAIL if_rdata_hold: got %h want 8c010004", a_if_rdata); else n_pass++;
  endtask

  task automatic test_mem_priority();
    bit seen;
    int n;
    do_reset();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h14;
    tick();
    n_total++; if (a_grant !== 2'd2) $display("FAIL mem_grant: got %0d want 2", a_grant); else n_pass++;
    n_total++; if (a_ram_en !== 1'b1 || a_ram_we !== 1'b1) $display("FAIL mem_issue: en/we %b%b want 11", a_ram_en, a_ram_we); else n_pass++;
    n_total++; if (a_ram_addr !== 32'h40 || a_ram_wdata !== 32'hDEADBEEF)
      $display("FAIL mem_bus: addr %h data %h want 00000040 deadbeef", a_ram_addr, a_ram_wdata); else n_pass++;
    tick();
    n_total++; if (a_mem_ack !== 1'b1 || a_if_ack !== 1'b0) $display("FAIL mem_ack: mem/if %b%b want 10", a_mem_ack, a_if_ack); else n_pass++;
    n_total++; if (a_ram_we !== 1'b0 || a_stall !== 1'b1) $display("FAIL mem_we_pulse: we/stall %b%b want 01", a_ram_we, a_stall); else n_pass++;
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    n_total++; if (a_grant !== 2'd0) $display("FAIL mem_idle: got %0d want 0", a_grant); else n_pass++;
    tick();
    n_total++; if (a_grant !== 2'd1 || a_ram_addr !== 32'h14) $display("FAIL if_next: grant %0d addr %h want 1 00000014", a_grant, a_ram_addr); else n_pass++;
    tick();
    n_total++; if (a_if_ack !== 1'b1 || a_if_rdata !== 32'hC0DE0014) $display("FAIL if_next_ack: ack %b data %h want 1 c0de0014", a_if_ack, a_if_rdata); else n_pass++;
    if_req = 1'b0;
    tick();
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h40;
    wait_sig(3, 8, seen, n);
    n_total++; if (seen !== 1'b1) $display("FAIL ld_readback_timeout: got %b want 1", seen); else n_pass++;
    n_total++; if (a_ld_rdata !== 32'hDEADBEEF) $display("FAIL ld_readback: got %h want deadbeef", a_ld_rdata); else n_pass++;
    ld_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_g [10] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    bit seen;
    int n;
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h30;
    for (int k = 0; k < 10; k++) begin
      wait_sig(0, 6, seen, n);
      n_total++; if (seen !== 1'b1) $display("FAIL starve_issue_timeout[%0d]: got %b want 1", k, seen); else n_pass++;
      n_total++; if (a_grant !== exp_g[k]) $display("FAIL starve_grant[%0d]: got %0d want %0d", k, a_grant, exp_g[k]); else n_pass++;
      tick();
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    bit seen;
    int n;
    int last_cyc;
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h24;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_sig(0, 6, seen, n);
      n_total++; if (a_grant !== exp_g[k] || seen !== 1'b1) $display("FAIL rr_grant[%0d]: got %0d want %0d", k, a_grant, exp_g[k]); else n_pass++;
      if (k > 0) begin
        n_total++; if (cyc - last_cyc !== 2 + LAT_A) $display("FAIL rr_spacing[%0d]: got %0d want %0d", k, cyc - last_cyc, 2 + LAT_A); else n_pass++;
      end
      last_cyc = cyc;
      tick();
    end
    if_req = 1'b0; ld_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_lat3_ld();
    do_reset();
    ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h20;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_total++; if (b_ram_en !== (k == 1)) $display("FAIL lat3_en[T+%0d]: got %b want %b", k, b_ram_en, k == 1); else n_pass++;
      n_total++; if (b_ld_ack !== (k == 4)) $display("FAIL lat3_ack[T+%0d]: got %b want %b", k, b_ld_ack, k == 4); else n_pass++;
      n_total++; if ({b_if_ack, b_mem_ack} !== 2'b00) $display("FAIL lat3_other_ack[T+%0d]: got %b want 00", k, {b_if_ack, b_mem_ack}); else n_pass++;
      if (k == 4) begin
        n_total++; if (b_ld_rdata !== 32'hC0DE0020) $display("FAIL lat3_rdata: got %h want c0de0020", b_ld_rdata); else n_pass++;
        ld_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_in_wait();
    bit seen;
    int n;
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    tick();
    n_total++; if (b_ram_en !== 1'b1) $display("FAIL rw_issue: got %b want 1", b_ram_en); else n_pass++;
    tick();
    rst = 1'b1; if_req = 1'b0;
    tick();
    rst = 1'b0;
    n_total++; if (b_grant !== 2'd0 || b_ram_en !== 1'b0) $display("FAIL rw_idle: grant %0d en %b want 0 0", b_grant, b_ram_en); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_total++; if (b_if_ack !== 1'b0) $display("FAIL rw_no_ack[%0d]: got %b want 0", k, b_if_ack); else n_pass++;
      tick();
    end
    if_req = 1'b1; if_addr = 32'h14;
    wait_sig(5, 8, seen, n);
    n_total++; if (seen !== 1'b1 || n !== 1 + LAT_B) $display("FAIL rw_fresh_latency: seen %b cycles %0d want 1 %0d", seen, n, 1 + LAT_B); else n_pass++;
    n_total++; if (b_if_rdata !== 32'hC0DE0014) $display("FAIL rw_fresh_rdata: got %h want c0de0014", b_if_rdata); else n_pass++;
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_if_read();
    test_mem_priority();
    test_starvation();
    test_back_to_back();
    test_lat3_ld();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
